// File: rtl/uart_reg_bridge_pkg.sv
// Shared command/response codes and FSM state encoding for the UART register bridge.
package uart_reg_bridge_pkg;

    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] RSP_OK  = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h3F;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GET_ADDR = 3'd1,
        ST_GET_DATA = 3'd2,
        ST_BUS_WR   = 3'd3,
        ST_BUS_RD   = 3'd4,
        ST_WAIT_RD  = 3'd5,
        ST_SEND     = 3'd6,
        ST_WAIT_TX  = 3'd7
    } state_t;

endpackage

// File: rtl/uart_reg_bridge_timer.sv
// Inactivity timer: counts while enabled, pulses EXPIRE on the last allowed cycle.
module uart_reg_bridge_timer #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic CLK,
    input  logic NRST,
    input  logic CLR,
    input  logic EN,
    output logic EXPIRE
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] count_reg;

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            count_reg <= '0;
        end else if (CLR) begin
            count_reg <= '0;
        end else if (EN) begin
            count_reg <= count_reg + CW'(1);
        end
    end

    // CLR is left out here: it depends on the FSM next state, which depends on EXPIRE.
    assign EXPIRE = EN && (count_reg == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/uart_reg_bridge.sv
// UART command responder driving a simple register bus ('W' addr data / 'R' addr).
// Optional byte echo is enabled by defining UART_REG_BRIDGE_ECHO_EN.
module uart_reg_bridge
    import uart_reg_bridge_pkg::*;
#(
    parameter int DATA_BITS      = 8,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                 CLK,
    input  logic                 NRST,
    input  logic [DATA_BITS-1:0] RX_DO,
    input  logic                 RX_DRDY,
    output logic [DATA_BITS-1:0] TX_DI,
    output logic                 TX_DRDY,
    input  logic                 TX_BUSY,
    input  logic                 TX_DONE,
    output logic [DATA_BITS-1:0] REG_ADDR,
    output logic [DATA_BITS-1:0] REG_WDATA,
    output logic                 REG_WE,
    output logic                 REG_RE,
    input  logic [DATA_BITS-1:0] REG_RDATA,
    input  logic                 REG_RVALID
);

    state_t                 state_reg, state_next;
    state_t                 ret_reg, ret_next;
    logic                   wr_flag_reg, wr_flag_next;
    logic [DATA_BITS-1:0]   rsp_reg, rsp_next;
    logic [DATA_BITS-1:0]   tx_di_reg, tx_di_next;
    logic                   tx_drdy_reg, tx_drdy_next;
    logic [DATA_BITS-1:0]   addr_reg, addr_next;
    logic [DATA_BITS-1:0]   wdata_reg, wdata_next;
    logic                   we_reg, we_next;
    logic                   re_reg, re_next;
    logic                   rx_accept;
    logic                   timer_clr;
    logic                   timer_en;
    logic                   expire;

    uart_reg_bridge_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .CLK   (CLK),
        .NRST  (NRST),
        .CLR   (timer_clr),
        .EN    (timer_en),
        .EXPIRE(expire)
    );

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            state_reg   <= ST_IDLE;
            ret_reg     <= ST_IDLE;
            wr_flag_reg <= 1'b0;
            rsp_reg     <= '0;
            tx_di_reg   <= '0;
            tx_drdy_reg <= 1'b0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            we_reg      <= 1'b0;
            re_reg      <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ret_reg     <= ret_next;
            wr_flag_reg <= wr_flag_next;
            rsp_reg     <= rsp_next;
            tx_di_reg   <= tx_di_next;
            tx_drdy_reg <= tx_drdy_next;
            addr_reg    <= addr_next;
            wdata_reg   <= wdata_next;
            we_reg      <= we_next;
            re_reg      <= re_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        ret_next     = ret_reg;
        wr_flag_next = wr_flag_reg;
        rsp_next     = rsp_reg;
        tx_di_next   = tx_di_reg;
        tx_drdy_next = 1'b0;
        addr_next    = addr_reg;
        wdata_next   = wdata_reg;
        rx_accept    = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (RX_DRDY) begin
                    rx_accept = 1'b1;
`ifdef UART_REG_BRIDGE_ECHO_EN
                    rsp_next   = RX_DO;
                    state_next = ST_SEND;
                    if (RX_DO == DATA_BITS'(CMD_WR) || RX_DO == DATA_BITS'(CMD_RD)) begin
                        wr_flag_next = (RX_DO == DATA_BITS'(CMD_WR));
                        ret_next     = ST_GET_ADDR;
                    end else begin
                        ret_next = ST_IDLE;
                    end
`else
                    if (RX_DO == DATA_BITS'(CMD_WR) || RX_DO == DATA_BITS'(CMD_RD)) begin
                        wr_flag_next = (RX_DO == DATA_BITS'(CMD_WR));
                        state_next   = ST_GET_ADDR;
                    end else begin
                        rsp_next   = DATA_BITS'(RSP_ERR);
                        state_next = ST_SEND;
                    end
`endif
                end
            end
            ST_GET_ADDR: begin
                // A byte arriving in the expiry cycle takes priority over the timeout.
                if (RX_DRDY) begin
                    rx_accept = 1'b1;
                    addr_next = RX_DO;
`ifdef UART_REG_BRIDGE_ECHO_EN
                    rsp_next   = RX_DO;
                    ret_next   = wr_flag_reg ? ST_GET_DATA : ST_BUS_RD;
                    state_next = ST_SEND;
`else
                    state_next = wr_flag_reg ? ST_GET_DATA : ST_BUS_RD;
`endif
                end else if (expire) begin
                    state_next = ST_IDLE;
                end
            end
            ST_GET_DATA: begin
                if (RX_DRDY) begin
                    rx_accept  = 1'b1;
                    wdata_next = RX_DO;
`ifdef UART_REG_BRIDGE_ECHO_EN
                    rsp_next   = RX_DO;
                    ret_next   = ST_BUS_WR;
                    state_next = ST_SEND;
`else
                    state_next = ST_BUS_WR;
`endif
                end else if (expire) begin
                    state_next = ST_IDLE;
                end
            end
            ST_BUS_WR: begin
                rsp_next   = DATA_BITS'(RSP_OK);
                ret_next   = ST_IDLE;
                state_next = ST_SEND;
            end
            ST_BUS_RD: begin
                state_next = ST_WAIT_RD;
            end
            ST_WAIT_RD: begin
                if (REG_RVALID) begin
                    rsp_next   = REG_RDATA;
                    ret_next   = ST_IDLE;
                    state_next = ST_SEND;
                end else if (expire) begin
                    rsp_next   = DATA_BITS'(RSP_ERR);
                    ret_next   = ST_IDLE;
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                if (!TX_BUSY) begin
                    tx_di_next   = rsp_reg;
                    tx_drdy_next = 1'b1;
                    state_next   = ST_WAIT_TX;
                end
            end
            ST_WAIT_TX: begin
                if (TX_DONE) begin
                    state_next = ret_reg;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Strobes are registered from the next state so they line up with BUS_WR/BUS_RD.
    assign we_next   = (state_next == ST_BUS_WR);
    assign re_next   = (state_next == ST_BUS_RD);
    assign timer_en  = (state_reg == ST_GET_ADDR) || (state_reg == ST_GET_DATA) ||
                       (state_reg == ST_WAIT_RD);
    assign timer_clr = rx_accept || (state_next != state_reg);

    assign TX_DI     = tx_di_reg;
    assign TX_DRDY   = tx_drdy_reg;
    assign REG_ADDR  = addr_reg;
    assign REG_WDATA = wdata_reg;
    assign REG_WE    = we_reg;
    assign REG_RE    = re_reg;

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Scoreboard bench for uart_reg_bridge: queued expectations for TX bytes and bus strobes.
module tb_uart_reg_bridge;

    localparam int TO = 100;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic [7:0] rx_do = 8'h00;
    logic       rx_drdy = 1'b0;
    logic [7:0] tx_di;
    logic       tx_drdy;
    logic       uart_busy = 1'b0;
    logic       hold_busy = 1'b0;
    logic       tx_busy;
    logic       tx_done = 1'b0;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata = 8'h00;
    logic       reg_rvalid = 1'b0;

    assign tx_busy = uart_busy | hold_busy;

    uart_reg_bridge #(
        .DATA_BITS     (8),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLK       (clk),
        .NRST      (nrst),
        .RX_DO     (rx_do),
        .RX_DRDY   (rx_drdy),
        .TX_DI     (tx_di),
        .TX_DRDY   (tx_drdy),
        .TX_BUSY   (tx_busy),
        .TX_DONE   (tx_done),
        .REG_ADDR  (reg_addr),
        .REG_WDATA (reg_wdata),
        .REG_WE    (reg_we),
        .REG_RE    (reg_re),
        .REG_RDATA (reg_rdata),
        .REG_RVALID(reg_rvalid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  exp_tx[$];
    logic [15:0] exp_wr[$];
    logic [7:0]  exp_rd[$];
    int          rd_lat = 0;
    logic [7:0]  rd_value = 8'h00;
    int          last_rx_cyc = 0;
    int          exp_tx_cyc = -1;
    logic        prev_drdy = 1'b0;
    logic        prev_we = 1'b0;
    logic        prev_re = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    // Output monitor / scoreboard consumer.
    initial forever begin
        @(negedge clk);
        if (nrst) begin
            if (tx_drdy) begin
                $display("tx byte 0x%02h at cycle %0d", tx_di, cyc);
                check_eq("tx_drdy_width", prev_drdy, 0);
                check_eq("tx_while_busy", hold_busy, 0);
                if (exp_tx.size() == 0) check_eq("tx_unexpected", exp_tx.size(), 1);
                else check_eq("tx_byte", tx_di, exp_tx.pop_front());
                if (exp_tx_cyc >= 0) begin
                    check_eq("tx_bp_latency", cyc, exp_tx_cyc);
                    exp_tx_cyc = -1;
                end
            end
            if (reg_we) begin
                $display("bus write addr 0x%02h data 0x%02h", reg_addr, reg_wdata);
                check_eq("we_width", prev_we, 0);
                check_eq("we_latency", cyc, last_rx_cyc);
                if (exp_wr.size() == 0) check_eq("we_unexpected", exp_wr.size(), 1);
                else check_eq("we_addr_data", {reg_addr, reg_wdata}, exp_wr.pop_front());
            end
            if (reg_re) begin
                $display("bus read addr 0x%02h", reg_addr);
                check_eq("re_width", prev_re, 0);
                check_eq("re_latency", cyc, last_rx_cyc);
                if (exp_rd.size() == 0) check_eq("re_unexpected", exp_rd.size(), 1);
                else check_eq("re_addr", reg_addr, exp_rd.pop_front());
            end
            prev_drdy = tx_drdy;
            prev_we   = reg_we;
            prev_re   = reg_re;
        end else begin
            prev_drdy = 1'b0;
            prev_we   = 1'b0;
            prev_re   = 1'b0;
        end
    end

    // Register file responder.
    initial forever begin
        @(negedge clk);
        if (nrst && reg_re && rd_lat > 0) begin
            repeat (rd_lat) @(negedge clk);
            reg_rdata  = rd_value;
            reg_rvalid = 1'b1;
            @(negedge clk);
            reg_rvalid = 1'b0;
            reg_rdata  = 8'h00;
        end
    end

    // UART transmitter model.
    initial forever begin
        @(negedge clk);
        if (nrst && tx_drdy) begin
            uart_busy = 1'b1;
            repeat (8) @(negedge clk);
            uart_busy = 1'b0;
            tx_done   = 1'b1;
            @(negedge clk);
            tx_done   = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_do       = b;
        rx_drdy     = 1'b1;
        last_rx_cyc = cyc + 1;
        @(negedge clk);
        rx_drdy     = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 3000; i++) begin
            if (exp_tx.size() == 0 && !uart_busy && !tx_done) break;
            @(negedge clk);
        end
        repeat (15) @(negedge clk);
        check_eq({tag, "_tx_pending"}, exp_tx.size(), 0);
        check_eq({tag, "_wr_pending"}, exp_wr.size(), 0);
        check_eq({tag, "_rd_pending"}, exp_rd.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_tx_di"},     tx_di, 0);
        check_eq({tag, "_tx_drdy"},   tx_drdy, 0);
        check_eq({tag, "_reg_addr"},  reg_addr, 0);
        check_eq({tag, "_reg_wdata"}, reg_wdata, 0);
        check_eq({tag, "_reg_we"},    reg_we, 0);
        check_eq({tag, "_reg_re"},    reg_re, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        nrst = 1'b1;
        repeat (2) @(negedge clk);

        // Write command.
        exp_wr.push_back({8'h10, 8'hA5});
        exp_tx.push_back(8'h4B);
        send_byte(8'h57); send_byte(8'h10); send_byte(8'hA5);
        drain("write");

        // Read command, data returned 3 cycles after the strobe.
        rd_lat = 3; rd_value = 8'h5C;
        exp_rd.push_back(8'h22);
        exp_tx.push_back(8'h5C);
        send_byte(8'h52); send_byte(8'h22);
        drain("read");

        // Unknown command.
        exp_tx.push_back(8'h3F);
        send_byte(8'h41);
        drain("unknown");

        // Inter-byte timeout: silent return to idle, then a normal read.
        send_byte(8'h57);
        repeat (120) @(negedge clk);
        rd_lat = 1; rd_value = 8'h99;
        exp_rd.push_back(8'h01);
        exp_tx.push_back(8'h99);
        send_byte(8'h52); send_byte(8'h01);
        drain("after_timeout");

        // Read timeout with transmitter backpressure.
        rd_lat = 0;
        exp_rd.push_back(8'h33);
        exp_tx.push_back(8'h3F);
        send_byte(8'h52); send_byte(8'h33);
        hold_busy = 1'b1;
        repeat (150) @(negedge clk);
        hold_busy  = 1'b0;
        exp_tx_cyc = cyc + 1;
        drain("rd_timeout");
        check_eq("bp_latency_seen", exp_tx_cyc, 32'hFFFF_FFFF);

        // Reset in the middle of a write.
        exp_wr.push_back({8'h10, 8'h00});
        send_byte(8'h57); send_byte(8'h10);
        repeat (2) @(negedge clk);
        check_eq("mid_addr_latched", reg_addr, 8'h10);
        nrst = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        exp_wr.delete();
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        exp_tx.push_back(8'h3F);
        send_byte(8'hA5);
        drain("post_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
